spectral_peak_picker: RTL and testbench

SPECTRAL_PEAK_PICKER -- requirements
Module: spectral_peak_picker

---
 rtl/spectral_peak_picker.sv | 227 ++++++++++++++++++++++
 tb/tb_spectral_peak_picker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectral_peak_picker.sv
// Scans one frame of magnitudes bin by bin, tracks the maximum of four
// frequency bands, then emits one record per band whose maximum clears
// MIN_MAG, lowest band first, over a valid/ready handshake.
module spectral_peak_picker #(
  parameter int NUM_BINS = 512,
  parameter int MAG_W    = 16,
  parameter int EDGE1    = 40,
  parameter int EDGE2    = 80,
  parameter int EDGE3    = 160,
  parameter int MIN_MAG  = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [8:0]       index,
  input  logic [MAG_W-1:0] magnitude,
  input  logic             magnitude_ready,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [1:0]       peak_band,
  output logic [8:0]       peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic             peak_last,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  localparam logic [8:0]       LAST_BIN  = 9'(NUM_BINS - 1);
  localparam logic [8:0]       B1_START  = 9'(EDGE1);
  localparam logic [8:0]       B2_START  = 9'(EDGE2);
  localparam logic [8:0]       B3_START  = 9'(EDGE3);
  localparam logic [MAG_W-1:0] THRESHOLD = MAG_W'(MIN_MAG);

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Scan position within the frame.
  logic [8:0] bin_cnt;

  // Running per-band maximum and the bin where it was first seen.
  logic [MAG_W-1:0] band_max [4];
  logic [8:0]       band_bin [4];

  // Lowest band number still eligible for emission in this frame (0..4).
  logic [2:0] emit_ptr;

  logic       accept;
  logic       last_accept;
  logic [1:0] cur_band;
  logic [3:0] present;
  logic       nxt_found;
  logic [1:0] nxt_band;
  logic       nxt_last;
  logic       handshake;
  logic       load;
  logic       enter_done;

  // A strobe only counts while scanning; in EMIT/DONE it is ignored and the
  // upstream keeps re-requesting the held index 0.
  assign accept      = (state == SCAN) && magnitude_ready;
  assign last_accept = accept && (bin_cnt == LAST_BIN);
  assign handshake   = peak_valid && peak_ready;

  // Band membership of the bin currently being accepted.
  always_comb begin
    cur_band = 2'd3;
    if (bin_cnt < B1_START) begin
      cur_band = 2'd0;
    end else if (bin_cnt < B2_START) begin
      cur_band = 2'd1;
    end else if (bin_cnt < B3_START) begin
      cur_band = 2'd2;
    end
  end

  // A band is reportable once its maximum reaches the threshold.
  always_comb begin
    present = '0;
    for (int b = 0; b < 4; b++) begin
      present[b] = (band_max[b] >= THRESHOLD);
    end
  end

  // Find the lowest present band at or above emit_ptr, and whether any
  // present band lies above it (that decides peak_last).
  always_comb begin
    nxt_found = 1'b0;
    nxt_band  = 2'd0;
    for (int b = 3; b >= 0; b--) begin
      if (present[b] && (3'(b) >= emit_ptr)) begin
        nxt_found = 1'b1;
        nxt_band  = 2'(b);
      end
    end
    nxt_last = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (present[b] && (2'(b) > nxt_band)) begin
        nxt_last = 1'b0;
      end
    end
  end

  // A new record is loaded when the output slot is empty, or when the
  // current one is accepted and more bands follow.
  assign load = (state == EMIT) && nxt_found &&
                (!peak_valid || (handshake && !peak_last));

  // Index request: look-ahead by one bin during a strobe so the upstream
  // fetches the next sample on the same edge; wraps to 0 after the last bin.
  always_comb begin
    index = 9'd0;
    if (state == SCAN) begin
      if (accept) begin
        index = last_accept ? 9'd0 : (bin_cnt + 9'd1);
      end else begin
        index = bin_cnt;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: scan the full frame, drain records, pulse done.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN: begin
        if (last_accept) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (!peak_valid && !nxt_found) begin
          state_nxt = DONE;
        end else if (handshake && peak_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = SCAN;
      end
      default: begin
        state_nxt = SCAN;
      end
    endcase
  end

  assign enter_done = (state == EMIT) && (state_nxt == DONE);

  // Bin counter: advances per accepted sample, wraps to 0 on the last bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt <= 9'd0;
    end else if (accept) begin
      bin_cnt <= last_accept ? 9'd0 : (bin_cnt + 9'd1);
    end
  end

  // Band maxima: strict greater-than keeps the lowest bin on ties; DC bin
  // is skipped; everything clears as the FSM re-enters SCAN.
  always_ff @(posedge clk) begin
    if (reset || (state == DONE)) begin
      for (int b = 0; b < 4; b++) begin
        band_max[b] <= '0;
        band_bin[b] <= 9'd0;
      end
    end else if (accept && (bin_cnt != 9'd0) && (magnitude > band_max[cur_band])) begin
      band_max[cur_band] <= magnitude;
      band_bin[cur_band] <= bin_cnt;
    end
  end

  // Emission pointer: restarts at band 0 for every frame, then moves just
  // past each band as its record is loaded.
  always_ff @(posedge clk) begin
    if (reset || last_accept) begin
      emit_ptr <= 3'd0;
    end else if (load) begin
      emit_ptr <= {1'b0, nxt_band} + 3'd1;
    end
  end

  // Output record register; held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_valid <= 1'b0;
      peak_band  <= 2'd0;
      peak_bin   <= 9'd0;
      peak_mag   <= '0;
      peak_last  <= 1'b0;
    end else if (load) begin
      peak_valid <= 1'b1;
      peak_band  <= nxt_band;
      peak_bin   <= band_bin[nxt_band];
      peak_mag   <= band_max[nxt_band];
      peak_last  <= nxt_last;
    end else if (handshake) begin
      peak_valid <= 1'b0;
    end
  end

  // Frame completion pulse and counter, both visible during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_done <= enter_done;
      if (enter_done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Directed bench for spectral_peak_picker: plays frames from a magnitude
// table, collects emitted records and compares them with hand-derived ones.
module tb_spectral_peak_picker;

  localparam int NB = 512;

  typedef struct packed {
    logic [1:0]  band;
    logic [8:0]  bin;
    logic [15:0] mag;
    logic        last;
  } rec_t;

  logic        clk;
  logic        reset;
  logic [8:0]  index;
  logic [15:0] magnitude;
  logic        magnitude_ready;
  logic        peak_valid;
  logic        peak_ready;
  logic [1:0]  peak_band;
  logic [8:0]  peak_bin;
  logic [15:0] peak_mag;
  logic        peak_last;
  logic        frame_done;
  logic [7:0]  frame_count;

  int   n_vec;
  int   n_err;
  logic [15:0] mem [NB];
  rec_t recs[$];
  logic seen_done;

  spectral_peak_picker dut (
    .clk            (clk),
    .reset          (reset),
    .index          (index),
    .magnitude      (magnitude),
    .magnitude_ready(magnitude_ready),
    .peak_valid     (peak_valid),
    .peak_ready     (peak_ready),
    .peak_band      (peak_band),
    .peak_bin       (peak_bin),
    .peak_mag       (peak_mag),
    .peak_last      (peak_last),
    .frame_done     (frame_done),
    .frame_count    (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_mem();
    for (int i = 0; i < NB; i++) mem[i] = 16'd0;
  endtask

  // Stream one frame, one strobe per cycle. gap_at inserts idle cycles
  // around that bin; abort_at applies reset instead of strobing that bin.
  task automatic scan_frame(input int gap_at, input int abort_at);
    int bad;
    int first_k;
    logic [8:0] first_got;
    logic [8:0] exp_idx;
    bad = 0;
    first_k = -1;
    first_got = 9'd0;
    for (int k = 0; k < NB; k++) begin
      if (k == abort_at) begin
        @(negedge clk);
        magnitude_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (k == gap_at) begin
        @(negedge clk);
        magnitude_ready = 1'b0;
        #1;
        n_vec++;
        if (index !== 9'(k)) begin
          n_err++;
          $display("FAIL idx_before_strobe: index=%0d required=%0d", index, k);
        end
      end
      @(negedge clk);
      magnitude = mem[k];
      magnitude_ready = 1'b1;
      #1;
      exp_idx = (k == NB - 1) ? 9'd0 : 9'(k + 1);
      if (index !== exp_idx) begin
        if (bad == 0) begin
          first_k = k;
          first_got = index;
        end
        bad++;
      end
      if (k == gap_at) begin
        @(negedge clk);
        magnitude_ready = 1'b0;
        #1;
        n_vec++;
        if (index !== 9'(k + 1)) begin
          n_err++;
          $display("FAIL idx_after_strobe: index=%0d required=%0d", index, k + 1);
        end
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idx_lookahead: %0d bad cycles, first at bin %0d index=%0d", bad, first_k, first_got);
    end
    @(negedge clk);
    magnitude_ready = 1'b0;
    #1;
    n_vec++;
    if (index !== 9'd0) begin
      n_err++;
      $display("FAIL idx_after_last: index=%0d required=0", index);
    end
  endtask

  // Drain the emit phase into recs. With stall_len>0 the first record is
  // held for that many cycles while ignored strobes are thrown at the DUT.
  task automatic collect(input int stall_len);
    logic stalled;
    rec_t snap;
    int   unstable;
    recs.delete();
    seen_done = 1'b0;
    stalled = 1'b0;
    unstable = 0;
    peak_ready = (stall_len == 0);
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(negedge clk);
      if (frame_done) begin
        seen_done = 1'b1;
      end else begin
        if (stall_len > 0 && peak_valid && !stalled) begin
          stalled = 1'b1;
          snap = {peak_band, peak_bin, peak_mag, peak_last};
          for (int s = 0; s < stall_len; s++) begin
            magnitude = 16'hFFFF;
            magnitude_ready = 1'b1;
            @(negedge clk);
            #1;
            if (!peak_valid || ({peak_band, peak_bin, peak_mag, peak_last} !== snap) ||
                (index !== 9'd0))
              unstable++;
          end
          magnitude_ready = 1'b0;
          n_vec++;
          if (unstable != 0) begin
            n_err++;
            $display("FAIL stall_hold: %0d unstable cycles, required 0", unstable);
          end
        end
        if (stalled || stall_len == 0) peak_ready = 1'b1;
        if (peak_valid && peak_ready)
          recs.push_back({peak_band, peak_bin, peak_mag, peak_last});
      end
    end
    n_vec++;
    if (!seen_done) begin
      n_err++;
      $display("FAIL frame_done_timeout: frame_done=0 required=1");
    end
    @(negedge clk);
    peak_ready = 1'b0;
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL frame_done_width: frame_done=%b required=0", frame_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    magnitude = 16'd0;
    magnitude_ready = 1'b0;
    peak_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({index, peak_valid, peak_band, peak_bin, peak_mag, peak_last, frame_done, frame_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: idx=%0d v=%b band=%0d bin=%0d mag=%0d last=%b done=%b cnt=%0d required all 0",
               index, peak_valid, peak_band, peak_bin, peak_mag, peak_last, frame_done, frame_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_peaks(input int stall_len, input logic [7:0] exp_cnt);
    rec_t exp [4];
    clear_mem();
    mem[5] = 16'd100; mem[50] = 16'd200; mem[100] = 16'd300; mem[400] = 16'd400;
    exp[0] = {2'd0, 9'd5,   16'd100, 1'b0};
    exp[1] = {2'd1, 9'd50,  16'd200, 1'b0};
    exp[2] = {2'd2, 9'd100, 16'd300, 1'b0};
    exp[3] = {2'd3, 9'd400, 16'd400, 1'b1};
    scan_frame(-1, -1);
    collect(stall_len);
    n_vec++;
    if (recs.size() != 4) begin
      n_err++;
      $display("FAIL peaks_count: got %0d records required 4", recs.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= int'(recs.size())) begin
        n_err++;
        $display("FAIL peaks_rec%0d: missing required %h", i, exp[i]);
      end else if (recs[i] !== exp[i]) begin
        n_err++;
        $display("FAIL peaks_rec%0d: got %h required %h", i, recs[i], exp[i]);
      end
    end
    #1;
    n_vec++;
    if (frame_count !== exp_cnt || index !== 9'd0) begin
      n_err++;
      $display("FAIL peaks_after: frame_count=%0d index=%0d required %0d and 0", frame_count, index, exp_cnt);
    end
  endtask

  // Runs a frame expected to yield exactly one record.
  task automatic test_one_record(input string name, input int gap_at, input rec_t exp,
                                 input logic [7:0] exp_cnt);
    scan_frame(gap_at, -1);
    collect(0);
    n_vec++;
    if (recs.size() != 1) begin
      n_err++;
      $display("FAIL %s_count: got %0d records required 1", name, recs.size());
    end else if (recs[0] !== exp) begin
      n_err++;
      $display("FAIL %s_rec: got %h required %h", name, recs[0], exp);
    end
    n_vec++;
    if (frame_count !== exp_cnt) begin
      n_err++;
      $display("FAIL %s_frame_count: got %0d required %0d", name, frame_count, exp_cnt);
    end
  endtask

  task automatic test_threshold();
    clear_mem();
    mem[0] = 16'hFFFF; mem[60] = 16'd15; mem[200] = 16'd16;
    test_one_record("threshold", -1, {2'd3, 9'd200, 16'd16, 1'b1}, 8'd2);
  endtask

  task automatic test_tie();
    clear_mem();
    mem[90] = 16'd500; mem[120] = 16'd500;
    test_one_record("tie", -1, {2'd2, 9'd90, 16'd500, 1'b1}, 8'd3);
  endtask

  task automatic test_index_timing();
    clear_mem();
    mem[3] = 16'd20;
    test_one_record("index", 7, {2'd0, 9'd3, 16'd20, 1'b1}, 8'd4);
  endtask

  task automatic test_empty_frame();
    clear_mem();
    mem[1] = 16'd15; mem[511] = 16'd15;
    scan_frame(-1, -1);
    collect(0);
    n_vec++;
    if (recs.size() != 0 || frame_count !== 8'd6) begin
      n_err++;
      $display("FAIL empty_frame: got %0d records cnt=%0d required 0 records cnt=6", recs.size(), frame_count);
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[5] = 16'd100; mem[50] = 16'd200; mem[250] = 16'd900;
    scan_frame(-1, 300);
    #1;
    n_vec++;
    if (frame_count !== 8'd0 || index !== 9'd0 || peak_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_state: cnt=%0d index=%0d valid=%b required 0 0 0", frame_count, index, peak_valid);
    end
    clear_mem();
    mem[10] = 16'd50;
    test_one_record("reset_mid", -1, {2'd0, 9'd10, 16'd50, 1'b1}, 8'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_peaks(0, 8'd1);
    test_threshold();
    test_tie();
    test_index_timing();
    test_single_peaks(10, 8'd5);
    test_empty_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
